// File: rtl/pipeline_skid_stage.sv
// Elastic pipeline register with a 2-entry skid buffer, hazard stall and flush.
// The main register always drives the outputs; the skid register catches the
// one entry that can arrive while the downstream is not accepting, so in_ready
// can be computed from state alone and full throughput is kept.
module pipeline_skid_stage #(
    parameter int unsigned       DATA_W      = 64,
    parameter int unsigned       CTRL_W      = 8,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    // Encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_fire;
    logic              out_fire;

    // Handshake and presentation: in_ready never looks at out_ready.
    assign in_ready  = (state_q != SKID) && !stall && !flush;
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready && !stall && !flush;
    assign out_data  = main_data_q;
    assign out_ctrl  = out_valid ? main_ctrl_q : CTRL_BUBBLE;
    assign occupancy = 2'(state_q);

    // Next-state and storage update; flush wins over every handshake.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d     = FULL;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (in_fire) begin
                        state_d     = SKID;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        state_d     = FULL;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State and storage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= CTRL_BUBBLE;
            skid_data_q <= '0;
            skid_ctrl_q <= CTRL_BUBBLE;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// Bench for pipeline_skid_stage: a queue of held entries serves as the
// reference, directed scenarios pin it with literal values, then random traffic.
module tb_pipeline_skid_stage;

    localparam int unsigned       DATA_W = 64;
    localparam int unsigned       CTRL_W = 8;
    localparam logic [CTRL_W-1:0] BUB    = 8'h00;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
    } ent_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              stall;
    logic              flush;
    logic [1:0]        occupancy;

    ent_t q[$];
    bit   rst_clean;
    int   n_chk  = 0;
    int   n_fail = 0;

    pipeline_skid_stage #(
        .DATA_W     (DATA_W),
        .CTRL_W     (CTRL_W),
        .CTRL_BUBBLE(BUB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .stall    (stall),
        .flush    (flush),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Outputs must match what the queue of held entries implies.
    task automatic model_check();
        bit v;
        v = (q.size() > 0);
        chk("out_valid", 64'(out_valid), 64'(v));
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("in_ready", 64'(in_ready), 64'((q.size() < 2) && !stall && !flush));
        if (v) begin
            chk("out_data", out_data, q[0].d);
            chk("out_ctrl", 64'(out_ctrl), 64'(q[0].c));
        end else begin
            chk("out_ctrl_bubble", 64'(out_ctrl), 64'(BUB));
            if (rst_clean) chk("out_data_after_reset", out_data, 64'd0);
        end
    endtask

    // One clock of stimulus: drive, check, advance the model at the edge.
    task automatic step(input bit iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                        input bit ordy, input bit st, input bit fl, input bit rst);
        bit   inf;
        bit   outf;
        logic r0;
        ent_t e;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        reset     = rst;
        #1;
        model_check();
        r0        = in_ready;
        out_ready = !ordy;
        #1;
        chk("in_ready_indep_out_ready", 64'(in_ready), 64'(r0));
        out_ready = ordy;
        #1;
        inf  = iv && (q.size() < 2) && !st && !fl;
        outf = (q.size() > 0) && ordy && !st && !fl;
        @(posedge clk);
        if (rst) begin
            q.delete();
            rst_clean = 1'b1;
        end else if (fl) begin
            q.delete();
        end else begin
            if (outf) void'(q.pop_front());
            if (inf) begin
                e.d = d;
                e.c = c;
                q.push_back(e);
                rst_clean = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [DATA_W-1:0] rd;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        q.delete();
        rst_clean = 1'b1;
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_occupancy", 64'(occupancy), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_data", out_data, 64'd0);

        // Streaming at full rate.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 64'(i), 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            chk("stream_data", out_data, 64'(i));
            chk("stream_occ", 64'(occupancy), 64'd1);
            chk("stream_in_ready", 64'(in_ready), 64'd1);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("stream_drained", 64'(out_valid), 64'd0);

        // Backpressure fills the skid; C waits upstream.
        step(1'b1, 64'hA, 8'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'hB, 8'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'hC, 8'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_occ", 64'(occupancy), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_head", out_data, 64'hA);
        step(1'b1, 64'hC, 8'h3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_second", out_data, 64'hB);
        step(1'b1, 64'hC, 8'h3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_third", out_data, 64'hC);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_drained", 64'(occupancy), 64'd0);

        // Stall freezes a full stage.
        step(1'b1, 64'hA, 8'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'hB, 8'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 64'h77, 8'h7, 1'b1, 1'b1, 1'b0, 1'b0);
            chk("stall_data", out_data, 64'hA);
            chk("stall_occ", 64'(occupancy), 64'd2);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("stall_release", out_data, 64'hB);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("stall_drained", 64'(out_valid), 64'd0);

        // Flush together with stall drops the entry and the offered input.
        step(1'b1, 64'h11, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("flush_pre_ctrl", 64'(out_ctrl), 64'h5A);
        step(1'b1, 64'h99, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ctrl", 64'(out_ctrl), 64'(BUB));
        chk("flush_occ", 64'(occupancy), 64'd0);
        repeat (2) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a transfer.
        step(1'b1, 64'hA, 8'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'hB, 8'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'hEE, 8'hE, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        step(1'b1, 64'h42, 8'h9, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_first", out_data, 64'h42);

        // Random traffic against the queue model.
        for (int i = 0; i < 3000; i++) begin
            rd = {$urandom(), $urandom()};
            step(($urandom_range(0, 3) != 0), rd, 8'($urandom()),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 10), ($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
